// File: rtl/sapra_irq_pkg.sv
// sapra_irq_pkg
// Shared definitions for the sapra interrupt controller:
//   - irq_state_e   : handshake FSM state (IDLE / REQ / SERV), 2 bits
//   - SIG_*_LSB     : bit positions of the fields inside the IRQ_SIG status word
//   - IRQ_NONE      : IRQ_NUM / in-service value meaning "no interrupt"
package sapra_irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } irq_state_e;

    localparam int SIG_PEND_LSB  = 0;
    localparam int SIG_MASK_LSB  = 4;
    localparam int SIG_INSVC_LSB = 8;
    localparam int SIG_STATE_LSB = 12;

    localparam logic [1:0] IRQ_NONE = 2'd0;

endpackage

// File: rtl/sapra_irq_sync.sv
// sapra_irq_sync
// One external interrupt line: two-flop synchroniser (s1, s2) followed by a
// delay flop (s3). edge_o is high for exactly one cycle after the line has
// been seen going from low to high.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   irq_in in  raw asynchronous interrupt line
//   edge_o out rising-edge pulse, driven only from flops
module sapra_irq_sync
    import sapra_irq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic irq_in,
    output logic edge_o
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = irq_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // s2 is the first metastability-safe copy; s3 is its previous value.
    assign edge_o = s2_q & ~s3_q;

endmodule

// File: rtl/sapra_irq_ctrl.sv
// sapra_irq_ctrl
// Fixed-priority interrupt controller feeding the sapra MIPS core.
// Ports:
//   CLOCK_50   in   system clock (rising edge)
//   KEY        in   asynchronous active-low reset
//   irq_in     in   raw interrupt lines, bit 0 = highest priority
//   mask_we    in   mask register write strobe
//   mask_wdata in   new mask value (1 = enabled)
//   irq_ack    in   core took the interrupt (one-cycle pulse)
//   irq_eoi    in   core finished the handler (one-cycle pulse)
//   irq_req    out  request to the core
//   IRQ_NUM    out  granted source index + 1, 0 = none
//   IRQ_ADDR   out  handler vector VEC_BASE + index (mod 16)
//   IRQ_SIG    out  status: pending, mask, in-service number, FSM state
module sapra_irq_ctrl
    import sapra_irq_pkg::*;
#(
    parameter int                 NUM_IRQ  = 3,
    parameter logic [3:0]         VEC_BASE = 4'h8,
    parameter logic [NUM_IRQ-1:0] MASK_RST = {NUM_IRQ{1'b1}}
) (
    input  logic               CLOCK_50,
    input  logic               KEY,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               irq_ack,
    input  logic               irq_eoi,
    output logic               irq_req,
    output logic [1:0]         IRQ_NUM,
    output logic [3:0]         IRQ_ADDR,
    output logic [15:0]        IRQ_SIG
);

    // Handshake with the core: irq_req rises with IRQ_NUM/IRQ_ADDR already
    // valid and all three stay frozen until irq_ack is sampled in REQ; the
    // acknowledge retires the request. The grant then stays in service until
    // irq_eoi is sampled in SERV. Strobes seen in any other state are ignored.

    logic [NUM_IRQ-1:0] edge_det;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        sapra_irq_sync u_sync (
            .clk    (CLOCK_50),
            .rst_n  (KEY),
            .irq_in (irq_in[g]),
            .edge_o (edge_det[g])
        );
    end

    irq_state_e         state_q, state_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic               irq_req_q, irq_req_d;
    logic [1:0]         irq_num_q, irq_num_d;
    logic [3:0]         irq_addr_q, irq_addr_d;
    logic [1:0]         in_svc_q, in_svc_d;

    // Priority encoder: scan downwards so the lowest set index wins.
    logic [NUM_IRQ-1:0] cand;
    logic               win_valid;
    logic [1:0]         win_idx;
    logic [1:0]         win_num;
    logic [3:0]         win_addr;

    always_comb begin
        cand      = pend_q & mask_q;
        win_valid = |cand;
        win_idx   = 2'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_idx = 2'(i);
            end
        end
        win_num  = win_idx + 2'd1;
        win_addr = VEC_BASE + {2'b00, win_idx};
    end

    // One-hot of the source currently held in IRQ_NUM.
    logic [NUM_IRQ-1:0] grant_oh;

    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_num_q == 2'(i + 1)) begin
                grant_oh[i] = 1'b1;
            end
        end
    end

    logic [NUM_IRQ-1:0] pend_clr;

    always_comb begin
        state_d    = state_q;
        irq_req_d  = irq_req_q;
        irq_num_d  = irq_num_q;
        irq_addr_d = irq_addr_q;
        in_svc_d   = in_svc_q;
        pend_clr   = '0;

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    irq_num_d  = win_num;
                    irq_addr_d = win_addr;
                    irq_req_d  = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    pend_clr  = grant_oh;
                    irq_req_d = 1'b0;
                    in_svc_d  = irq_num_q;
                    state_d   = ST_SERV;
                end
            end
            ST_SERV: begin
                if (irq_eoi) begin
                    in_svc_d  = IRQ_NONE;
                    irq_num_d = IRQ_NONE;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new edge beats the acknowledge clear so it is never lost.
        pend_d = (pend_q & ~pend_clr) | edge_det;
        // The new mask is only visible to arbitration from the next cycle.
        mask_d = mask_we ? mask_wdata : mask_q;
    end

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            state_q    <= ST_IDLE;
            pend_q     <= '0;
            mask_q     <= MASK_RST;
            irq_req_q  <= 1'b0;
            irq_num_q  <= IRQ_NONE;
            irq_addr_q <= 4'h0;
            in_svc_q   <= IRQ_NONE;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            irq_req_q  <= irq_req_d;
            irq_num_q  <= irq_num_d;
            irq_addr_q <= irq_addr_d;
            in_svc_q   <= in_svc_d;
        end
    end

    assign irq_req  = irq_req_q;
    assign IRQ_NUM  = irq_num_q;
    assign IRQ_ADDR = irq_addr_q;

    always_comb begin
        IRQ_SIG = 16'h0000;
        IRQ_SIG[SIG_PEND_LSB  +: NUM_IRQ] = pend_q;
        IRQ_SIG[SIG_MASK_LSB  +: NUM_IRQ] = mask_q;
        IRQ_SIG[SIG_INSVC_LSB +: 2]       = in_svc_q;
        IRQ_SIG[SIG_STATE_LSB +: 2]       = state_q;
    end

endmodule
